// File: rtl/note_playback_if.sv
// Melody playback bus: play enable and note array in, presented note and status out.
interface note_playback_if;
  logic                toggle_in;
  logic [159:0][5:0]   notes_in;
  logic [5:0]          note_out;
  logic                note_start;
  logic [7:0]          index_out;
  logic                playing;
  logic                done;

  modport master (
    output toggle_in, notes_in,
    input  note_out, note_start, index_out, playing, done
  );

  modport slave (
    input  toggle_in, notes_in,
    output note_out, note_start, index_out, playing, done
  );
endinterface

// File: rtl/note_playback.sv
// Steps a 160-slot note array one slot per EIGHTH_CYCLES clocks; all outputs registered,
// one-edge start/stop latency; no backpressure, toggle_in low rewinds immediately.
module note_playback #(
  parameter int EIGHTH_CYCLES = 37125000,
  parameter int NUM_NOTES     = 160
) (
  input logic       clk_in,
  input logic       rst_in,
  note_playback_if.slave pb
);
  localparam int CW = $clog2(EIGHTH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(EIGHTH_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_NOTES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    idx_q;
  logic [5:0]    note_q;
  logic          start_q;
  logic          playing_q;
  logic          done_q;
  logic [5:0]    nxt_note;

  // Array is read live so edits to future slots take effect when reached.
  assign nxt_note = pb.notes_in[idx_q + 8'd1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      note_q    <= '0;
      start_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          idx_q     <= '0;
          done_q    <= 1'b0;
          if (pb.toggle_in) begin
            state_q   <= PLAY;
            note_q    <= pb.notes_in[0];
            start_q   <= (pb.notes_in[0] != 6'd0);
            playing_q <= 1'b1;
          end else begin
            note_q    <= '0;
            playing_q <= 1'b0;
          end
        end
        PLAY: begin
          if (!pb.toggle_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            note_q    <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (idx_q < IDX_LAST) begin
              idx_q   <= idx_q + 8'd1;
              note_q  <= nxt_note;
              // Equal consecutive codes tie into one held note.
              start_q <= (nxt_note != 6'd0) && (nxt_note != note_q);
            end else begin
              state_q   <= DONE;
              note_q    <= '0;
              playing_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (!pb.toggle_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            note_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          idx_q     <= '0;
          note_q    <= '0;
          playing_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pb.note_out   = note_q;
  assign pb.note_start = start_q;
  assign pb.index_out  = idx_q;
  assign pb.playing    = playing_q;
  assign pb.done       = done_q;
endmodule

// File: tb/tb_note_playback.sv
// Directed bench: short-slot instance for sequencing/control, 160-slot instance for full-array run.
module tb_note_playback;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk_in = ~clk_in;

  note_playback_if bus_a ();
  note_playback_if bus_b ();

  note_playback #(.EIGHTH_CYCLES(4), .NUM_NOTES(4)) dut_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .pb     (bus_a.slave)
  );

  note_playback #(.EIGHTH_CYCLES(2), .NUM_NOTES(160)) dut_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .pb     (bus_b.slave)
  );

  // Expected per-edge values for notes {5,5,0,9}, 4 cycles per slot; edge 17 is DONE.
  int exp_note  [17] = '{5,5,5,5, 5,5,5,5, 0,0,0,0, 9,9,9,9, 0};
  int exp_start [17] = '{1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0, 0};
  int exp_idx   [17] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 3};

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input int note, input int start, input int idx,
                       input int play, input int dn);
    chk({tag, ".note"},    int'(bus_a.note_out),   note);
    chk({tag, ".start"},   int'(bus_a.note_start), start);
    chk({tag, ".index"},   int'(bus_a.index_out),  idx);
    chk({tag, ".playing"}, int'(bus_a.playing),    play);
    chk({tag, ".done"},    int'(bus_a.done),       dn);
  endtask

  initial begin
    int starts;
    bus_a.toggle_in = 1'b0;
    bus_a.notes_in  = '0;
    bus_a.notes_in[0] = 6'd5;
    bus_a.notes_in[1] = 6'd5;
    bus_a.notes_in[2] = 6'd0;
    bus_a.notes_in[3] = 6'd9;
    bus_b.toggle_in = 1'b0;
    for (int k = 0; k < 160; k++) bus_b.notes_in[k] = 6'd33;

    tick();
    tick();
    chk_a("reset", 0, 0, 0, 0, 0);
    rst_in = 1'b0;
    tick();
    chk_a("idle", 0, 0, 0, 0, 0);

    // Full playback of {5,5,0,9}.
    bus_a.toggle_in = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      chk($sformatf("seq%0d.note", c),  int'(bus_a.note_out),   exp_note[c]);
      chk($sformatf("seq%0d.start", c), int'(bus_a.note_start), exp_start[c]);
      chk($sformatf("seq%0d.index", c), int'(bus_a.index_out),  exp_idx[c]);
      chk($sformatf("seq%0d.playing", c), int'(bus_a.playing), (c < 16) ? 1 : 0);
      chk($sformatf("seq%0d.done", c),  int'(bus_a.done),       (c < 16) ? 0 : 1);
    end

    // DONE holds with toggle still high.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_a($sformatf("hold%0d", c), 0, 0, 3, 0, 1);
    end

    bus_a.toggle_in = 1'b0;
    tick();
    chk_a("done_stop", 0, 0, 0, 0, 0);

    // Stop mid slot 1, then restart.
    bus_a.toggle_in = 1'b1;
    repeat (6) tick();
    chk_a("mid_slot1", 5, 0, 1, 1, 0);
    bus_a.toggle_in = 1'b0;
    tick();
    chk_a("mid_stop", 0, 0, 0, 0, 0);
    bus_a.toggle_in = 1'b1;
    tick();
    chk_a("restart", 5, 1, 0, 1, 0);

    // Synchronous reset mid-slot overrides toggle, then replays from slot 0.
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
    chk_a("rst_mid", 0, 0, 0, 0, 0);
    rst_in = 1'b0;
    tick();
    chk_a("rst_restart", 5, 1, 0, 1, 0);

    // Live edit of slot 2 while slot 1 is presented.
    bus_a.toggle_in = 1'b0;
    bus_a.notes_in[2] = 6'd7;
    tick();
    bus_a.toggle_in = 1'b1;
    repeat (6) tick();
    chk_a("edit_slot1", 5, 0, 1, 1, 0);
    bus_a.notes_in[2] = 6'd12;
    repeat (2) tick();
    chk_a("edit_pre", 5, 0, 1, 1, 0);
    tick();
    chk_a("edit_slot2", 12, 1, 2, 1, 0);
    tick();
    chk_a("edit_slot2b", 12, 0, 2, 1, 0);
    bus_a.toggle_in = 1'b0;

    // 160 slots of one repeated code, 2 cycles per slot.
    bus_b.toggle_in = 1'b1;
    tick();
    chk("full.first_note",  int'(bus_b.note_out),   33);
    chk("full.first_start", int'(bus_b.note_start), 1);
    chk("full.first_index", int'(bus_b.index_out),  0);
    starts = 0;
    for (int e = 2; e <= 320; e++) begin
      tick();
      if (bus_b.note_start) starts++;
      if (e == 319) begin
        chk("full.last_index", int'(bus_b.index_out), 159);
        chk("full.last_note",  int'(bus_b.note_out),  33);
        chk("full.last_done",  int'(bus_b.done),      0);
      end
    end
    chk("full.playing_end", int'(bus_b.playing), 1);
    chk("full.extra_starts", starts, 0);
    tick();
    chk("full.done",    int'(bus_b.done),      1);
    chk("full.playing", int'(bus_b.playing),   0);
    chk("full.index",   int'(bus_b.index_out), 159);
    chk("full.note",    int'(bus_b.note_out),  0);
    bus_b.toggle_in = 1'b0;
    tick();
    chk("full.stop_done", int'(bus_b.done), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/note_playback.md
# note_playback

Sequencer that replays a recorded melody. It steps through a 160-slot array of 6-bit note codes, one slot per eighth-note period, and presents the current note to the downstream tone/display logic. It pairs with the recording block that fills the same array at the same eighth-note rate. Slot value 0 is a rest. A one-cycle strobe marks each note onset so a downstream voice can retrigger.

## Interface
- EIGHTH_CYCLES, 37125000: clock cycles per slot (0.5 s at 74.25 MHz); must be ≥ 2.
- NUM_NOTES, 160: number of slots played; must be ≤ 160 and ≥ 1.
- clk_in  input  1  system clock; one clock domain.
- rst_in  input  1  synchronous, active-high reset.
- toggle_in  input  1  level play enable: high = play, low = stop/rewind.
- notes_in  input  [159:0][5:0]  melody array; slot k = notes_in[k].
- note_out  output  6  current note code; 0 = rest/silent.
- note_start  output  1  one-cycle pulse at the onset of a new sounding note.
- index_out  output  8  slot currently presented.
- playing  output  1  high while in PLAY.
- done  output  1  high after the last slot has completed, until toggle_in drops.

## Operation
- Counter width is $clog2(EIGHTH_CYCLES). Index is 8 bits.
- States: IDLE, PLAY, DONE.
- IDLE:
  - Outputs: note_out=0, note_start=0, index_out=0, playing=0, done=0.
  - On toggle_in=1, go to PLAY. On that same edge: index=0, counter=0, note_out<=notes_in[0], playing<=1, note_start<=(notes_in[0]!=0).
- PLAY:
  - counter increments every cycle.
  - When counter==EIGHTH_CYCLES-1 and index<NUM_NOTES-1: index<=index+1, counter<=0, note_out<=notes_in[index+1].
  - In that step, note_start<=1 only if notes_in[index+1]!=0 and notes_in[index+1]!=note_out. Repeated equal codes are a tie: no retrigger.
  - When counter==EIGHTH_CYCLES-1 and index==NUM_NOTES-1: go to DONE with note_out<=0, playing<=0, done<=1. index_out holds NUM_NOTES-1.
  - note_start is 0 on every other cycle.
- DONE:
  - Holds its outputs; no wrap-around and no replay.
  - To replay, toggle_in must go low (return to IDLE), then high again.
- toggle_in=0 in PLAY or DONE: go to IDLE on the next edge. All outputs take their IDLE values and counter/index clear. This overrides a slot step in the same cycle.
- notes_in is read live at each slot step, not snapshotted. Changes to slots not yet reached are reflected when they are reached.
- rst_in: from any state, on the next edge go to IDLE with all outputs 0. rst_in overrides toggle_in.

## Timing
- Reset value of every output is 0.
- Latency from toggle_in rising (sampled in IDLE) to note_out=notes_in[0] and playing=1 is one edge.
- Each slot is presented for exactly EIGHTH_CYCLES cycles.
- Total PLAY duration is NUM_NOTES×EIGHTH_CYCLES cycles. done rises EIGHTH_CYCLES cycles after the last slot appears.
- note_start is registered and coincident with the cycle note_out first shows the new code. Its width is exactly 1 cycle.
- Stop latency: one edge from toggle_in=0 to the IDLE outputs.
- A toggle_in glitch high for one cycle in IDLE starts playback; the next low cycle stops it. No debounce is done here; that happens upstream.

## Test plan
- EIGHTH_CYCLES=4, NUM_NOTES=4, notes {5,5,0,9}, toggle high and held:
  - note_out sequence is 5,5,0,9, each for 4 cycles, then 0.
  - note_start pulses only at slot 0 and slot 3.
  - done rises 16 cycles after start; playing falls on the same edge.
- Same setup, toggle dropped at cycle 6 (mid slot 1): next edge gives all outputs 0 and index 0. Raising toggle again restarts from slot 0 with a note_start pulse.
- DONE hold: after completion, keep toggle high for 20 more cycles. done stays 1, note_out stays 0, no note_start pulses.
- rst_in asserted mid-slot with toggle high: all outputs 0 next edge. After rst_in deasserts with toggle still high, playback restarts from slot 0.
- Live edit: while slot 1 plays, change notes_in[2] from 7 to 12. Slot 2 presents 12 with note_start=1.
- Default parameters (EIGHTH_CYCLES=37125000, NUM_NOTES=160), all slots=33:
  - single note_start at slot 0.
  - index_out reaches 159.
  - done at 160×37125000 cycles after start.
